// File: rtl/sum_chunk_seq.sv
// rtl/sum_chunk_seq.sv - chunked multi-cycle adder/subtractor with valid/ready handshakes
module sum_chunk_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Operands are shifted right each RUN cycle so the active chunk is always in the low bits.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    // Operand sign bits are kept aside because the shifting copies lose them.
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [CHUNK:0]     chunk_res;
    logic [WIDTH-1:0]   b_eff;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Register all state and outputs; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
        end
    end

    // Next-state logic: accept operands, ripple one chunk per cycle, hold result until taken.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;

        // Subtraction is a + ~b + ~borrow, so only the B side and carry-in are inverted.
        b_eff     = sub ? ~b : b;
        chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b_eff;
                    carry_d    = sub ? ~cin : cin;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b_eff[WIDTH-1];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // New chunk enters at the top; after NCHUNK shifts every chunk sits in place.
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_res[CHUNK];
                if (cnt_q == LAST_CNT) begin
                    cout_d      = chunk_res[CHUNK];
                    ovf_d       = (a_msb_q == b_msb_q) && (chunk_res[CHUNK-1] != a_msb_q);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
